// File: rtl/vx_tcu_drl_acc_sched.sv
// Round-robin scheduler sharing one fixed-latency TCU accumulator among NUM_REQS
// requesters, with credit-protected per-requester response queues.
module vx_tcu_drl_acc_sched #(
    parameter int unsigned NUM_REQS  = 4,
    parameter int unsigned N         = 5,
    parameter int unsigned WI        = 26,
    parameter int unsigned WO        = 30,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQS-1:0]                 req_valid,
    output logic [NUM_REQS-1:0]                 req_ready,
    input  logic [NUM_REQS-1:0][N-1:0][WI-1:0]  req_sigs,
    input  logic [NUM_REQS-1:0][N-1:0]          req_sticky,
    input  logic [NUM_REQS-1:0][N-2:0]          req_lane_mask,
    input  logic [NUM_REQS-1:0][TAG_W-1:0]      req_tag,
    output logic                                acc_valid,
    output logic [31:0]                         acc_req_id,
    output logic [N-1:0][WI-1:0]                acc_sigs,
    output logic [N-1:0]                        acc_sticky,
    output logic [N-2:0]                        acc_lane_mask,
    input  logic [WO-1:0]                       acc_sig_out,
    input  logic                                acc_sticky_out,
    output logic [NUM_REQS-1:0]                 rsp_valid,
    input  logic [NUM_REQS-1:0]                 rsp_ready,
    output logic [NUM_REQS-1:0][WO-1:0]         rsp_sig,
    output logic [NUM_REQS-1:0]                 rsp_sticky,
    output logic [NUM_REQS-1:0][TAG_W-1:0]      rsp_tag
);

    localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned CRD_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned AW    = $clog2(RSP_DEPTH);
    localparam int unsigned AIW   = (AW > 0) ? AW : 1;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned ENT_W = WO + 1 + TAG_W;
    localparam logic [PW-1:0] AMASK = PW'(RSP_DEPTH - 1);

    logic [NUM_REQS-1:0][CRD_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d, gnt_idx_c;
    logic                           gnt_any_c;
    logic [NUM_REQS-1:0]            eligible_c, grant_c, deq_c, wr_en_c;
    logic [31:0]                    iss_cnt_q;
    logic [IDX_W-1:0]               iss_own_q;
    logic [TAG_W-1:0]               iss_tag_q;
    logic                           tail_vld_c;
    logic [IDX_W-1:0]               tail_own_c;
    logic [TAG_W-1:0]               tail_tag_c;
    logic [NUM_REQS-1:0][PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ENT_W-1:0]               mem_q [NUM_REQS][RSP_DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            eligible_c[i] = req_valid[i] & (credit_q[i] != '0);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQS
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (!gnt_any_c && eligible_c[IDX_W'(idx)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IDX_W'(idx);
            end
        end
        grant_c = gnt_any_c ? (NUM_REQS'(1) << gnt_idx_c) : '0;
    end

    assign req_ready = grant_c & {NUM_REQS{reset_n}};
    assign deq_c     = rsp_valid & rsp_ready;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        credit_d = credit_q;
        if (gnt_any_c) begin
            rr_ptr_d = (gnt_idx_c == IDX_W'(NUM_REQS - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
        end
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (grant_c[i] && !deq_c[i]) begin
                credit_d[i] = credit_q[i] - CRD_W'(1);
            end else if (!grant_c[i] && deq_c[i]) begin
                credit_d[i] = credit_q[i] + CRD_W'(1);
            end
        end
    end

    // Arbiter state and accumulator issue register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= '0;
            credit_q      <= {NUM_REQS{CRD_W'(RSP_DEPTH)}};
            acc_valid     <= 1'b0;
            acc_req_id    <= '0;
            acc_sigs      <= '0;
            acc_sticky    <= '0;
            acc_lane_mask <= '0;
            iss_cnt_q     <= '0;
            iss_own_q     <= '0;
            iss_tag_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            credit_q  <= credit_d;
            acc_valid <= gnt_any_c;
            if (gnt_any_c) begin
                acc_sigs      <= req_sigs[gnt_idx_c];
                acc_sticky    <= req_sticky[gnt_idx_c];
                acc_lane_mask <= req_lane_mask[gnt_idx_c];
                acc_req_id    <= iss_cnt_q;
                iss_cnt_q     <= iss_cnt_q + 32'd1;
                iss_own_q     <= gnt_idx_c;
                iss_tag_q     <= req_tag[gnt_idx_c];
            end
        end
    end

    // Owner/tag tracking that mirrors the accumulator's fixed latency
    if (LATENCY == 0) begin : g_comb
        assign tail_vld_c = acc_valid;
        assign tail_own_c = iss_own_q;
        assign tail_tag_c = iss_tag_q;
    end else begin : g_pipe
        logic [LATENCY-1:0]            vld_q;
        logic [LATENCY-1:0][IDX_W-1:0] own_q;
        logic [LATENCY-1:0][TAG_W-1:0] tag_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= '0;
                own_q <= '0;
                tag_q <= '0;
            end else begin
                vld_q[0] <= acc_valid;
                own_q[0] <= iss_own_q;
                tag_q[0] <= iss_tag_q;
                for (int unsigned s = 1; s < LATENCY; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    own_q[s] <= own_q[s-1];
                    tag_q[s] <= tag_q[s-1];
                end
            end
        end

        assign tail_vld_c = vld_q[LATENCY-1];
        assign tail_own_c = own_q[LATENCY-1];
        assign tail_tag_c = tag_q[LATENCY-1];
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            wr_en_c[i] = tail_vld_c && (tail_own_c == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                if (wr_en_c[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                if (deq_c[i])   rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
            end
        end
    end

    // Queue storage needs no reset: pointers alone define occupancy
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (wr_en_c[i]) begin
                mem_q[i][AIW'(wr_ptr_q[i] & AMASK)] <= {acc_sig_out, acc_sticky_out, tail_tag_c};
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            rsp_valid[i] = (wr_ptr_q[i] != rd_ptr_q[i]);
            {rsp_sig[i], rsp_sticky[i], rsp_tag[i]} = mem_q[i][AIW'(rd_ptr_q[i] & AMASK)];
        end
    end

endmodule

// File: doc/vx_tcu_drl_acc_sched.md
# vx_tcu_drl_acc_sched

Round-robin scheduler that shares one TCU dot-product accumulator datapath between NUM_REQS requesters. Each requester hands over one accumulation operand set: N significands, sticky bits, lane mask and a tag. The block issues at most one set per cycle to the accumulator. It tracks each set through the accumulator's fixed pipeline latency and returns the packed sign-magnitude result to the owning requester through a per-requester response queue. Per-requester credits guarantee that the queues never overflow, because the accumulator pipeline cannot stall.

## Interface
Parameters:
- NUM_REQS, 4: number of requesters; must be ≥2.
- N, 5: operands per set; lanes 0..N-2 are vector lanes, lane N-1 is the C-term.
- WI, 26: input significand width.
- WO, 30: accumulator result width (packed sign-magnitude).
- LATENCY, 2: accumulator cycles from acc_valid to result; 0 means a combinational datapath.
- TAG_W, 8: requester tag width.
- RSP_DEPTH, 4: response queue depth per requester; must be a power of 2 and ≥1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  request valid, one bit per requester.
- req_ready  out  NUM_REQS  request accepted (grant).
- req_sigs  in  NUM_REQS×N×WI  operand significands.
- req_sticky  in  NUM_REQS×N  operand sticky bits.
- req_lane_mask  in  NUM_REQS×(N-1)  vector lane mask.
- req_tag  in  NUM_REQS×TAG_W  opaque tag, returned unchanged.
- acc_valid  out  1  issue strobe to the accumulator.
- acc_req_id  out  32  running issue id, for trace.
- acc_sigs  out  N×WI  issued significands.
- acc_sticky  out  N  issued sticky bits.
- acc_lane_mask  out  N-1  issued lane mask.
- acc_sig_out  in  WO  accumulator result, valid LATENCY cycles after issue.
- acc_sticky_out  in  1  accumulator sticky result.
- rsp_valid  out  NUM_REQS  response available.
- rsp_ready  in  NUM_REQS  response consumed.
- rsp_sig  out  NUM_REQS×WO  head-of-queue result.
- rsp_sticky  out  NUM_REQS  head-of-queue sticky.
- rsp_tag  out  NUM_REQS×TAG_W  head-of-queue tag.

## Operation
- Credits: one counter per requester, width clog2(RSP_DEPTH+1), reset to RSP_DEPTH.
  - Grant to requester i: credit[i] decrements.
  - Dequeue (rsp_valid[i] & rsp_ready[i]): credit[i] increments.
  - Grant and dequeue for the same requester in the same cycle: credit[i] is unchanged.
  - Credit never exceeds RSP_DEPTH and never goes below 0.
- Eligibility: eligible[i] = req_valid[i] & (credit[i] != 0).
- Arbitration: round-robin with pointer rr_ptr, reset 0.
  - Search starts at rr_ptr and wraps modulo NUM_REQS.
  - The first eligible requester is granted.
  - After a grant to requester i, rr_ptr ← (i+1) mod NUM_REQS. With no grant, rr_ptr holds.
  - At most one req_ready bit is high per cycle. req_ready is combinational from req_valid, credits and rr_ptr.
  - A requester may drop req_valid while not granted; the scheduler imposes no ordering constraint on it.
- Issue register: on a grant, the next edge loads acc_sigs, acc_sticky, acc_lane_mask, acc_req_id and acc_valid=1.
  - With no grant, acc_valid=0 and the data outputs hold their last value.
  - acc_req_id takes the value of a 32-bit issue counter that increments once per grant and wraps at 2^32.
- Tracking pipe: LATENCY stages carrying {valid, owner index, tag}, advancing every cycle with no stall.
  - When a valid entry reaches the tail, acc_sig_out and acc_sticky_out are sampled in that same cycle.
  - The sampled result, the sticky bit and the tag are written into queue[owner] at the next edge.
- Response queues: FIFO per requester with read/write pointers of width clog2(RSP_DEPTH)+1 and wrap-around.
  - rsp_* outputs show the head entry; rsp_valid[i] = queue i not empty.
  - Writing into a full queue cannot occur given credits. The bench checks this with an assertion.
  - Write and read on the same queue in the same cycle are both performed, with no bypass.
  - A write into an empty queue becomes visible on rsp_valid the next cycle.
- Ordering: per requester, responses come back in grant order. Across requesters, no ordering is guaranteed.

## Timing
- Reset values (async on reset_n low):
  - req_ready=0, acc_valid=0, acc_req_id=0, acc data outputs 0.
  - rsp_valid=0, queues empty, tracking pipe cleared.
  - credits=RSP_DEPTH, rr_ptr=0.
- Reset mid-operation discards all in-flight and queued results; no response is produced for them.
- Latency: a grant at cycle t gives acc_valid at t+1, result sampling at t+1+LATENCY, and rsp_valid at t+2+LATENCY (queue previously empty).
- Throughput: 1 set per cycle sustained, as long as credits remain.
- A response dequeued at cycle t restores credit for a grant at cycle t+1.

## Test plan
- Single request, LATENCY=2, requester 1 sends sigs {1,2,3,4,-20}, mask 4'b1111, tag 0x5A → acc_valid at t+1; rsp_valid[1] at t+4 with rsp_sig sign=1, magnitude=10, rsp_tag=0x5A.
- All four requesters hold valid continuously with rsp_ready=1 → grants go 0,1,2,3,0,1,… one per cycle; acc_req_id goes 0,1,2,…
- Requester 2 sends continuously with rsp_ready[2]=0, RSP_DEPTH=4 → exactly 4 grants, then req_ready[2]=0; raising rsp_ready[2] for 1 cycle gives exactly 1 further grant.
- Grant and dequeue on the same requester in the same cycle → credit unchanged; the queue count stays within RSP_DEPTH over 100 random cycles.
- Assert reset_n low while 2 results are in flight and 3 are queued → all rsp_valid=0 immediately; after release, credits are 4 and no stale response appears.
- LATENCY=0 → the result is sampled in the acc_valid cycle; rsp_valid appears 2 cycles after the grant.
